// File: rtl/jtkcpu_busarb_pkg.sv
// Shared definitions for the CPU/DMA bus arbiter: state encoding, counter widths
// and the wait-timer preset helper.
package jtkcpu_busarb_pkg;

    localparam logic [1:0] ENC_CPU  = 2'd0;
    localparam logic [1:0] ENC_HREQ = 2'd1;
    localparam logic [1:0] ENC_DMA  = 2'd2;
    localparam logic [1:0] ENC_REL  = 2'd3;

    localparam int TMR_W   = 8;
    localparam int BURST_W = 8;

    typedef enum logic [1:0] {
        ST_CPU  = ENC_CPU,
        ST_HREQ = ENC_HREQ,
        ST_DMA  = ENC_DMA,
        ST_REL  = ENC_REL
    } state_t;

    // A wait of N ticks is a down-count from N-1; the state is left when the count is zero.
    function automatic logic [TMR_W-1:0] tmr_preset(input int ticks);
        return (ticks > 1) ? TMR_W'(ticks - 1) : '0;
    endfunction

endpackage

// File: rtl/jtkcpu_busarb_tmr.sv
// Loadable down-counter gated by cen; zero flag marks the end of a halt-latency
// or release-gap wait.
module jtkcpu_busarb_tmr
    import jtkcpu_busarb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cen) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/jtkcpu_busarb.sv
// CPU/DMA bus arbiter: halts the CPU, grants the bus to DMA after HALT_LAT cen ticks,
// returns it for GAP ticks. Optional burst limit enabled by JTKCPU_BUSARB_FAIR_EN.
//
// state | meaning
// CPU   | CPU owns the bus, no halt requested
// HREQ  | halt asserted, waiting HALT_LAT ticks before granting
// DMA   | DMA owns the bus
// REL   | bus handed back, writes blocked for GAP ticks
module jtkcpu_busarb
    import jtkcpu_busarb_pkg::*;
#(
    parameter int HALT_LAT  = 2,
    parameter int BURST_MAX = 16,
    parameter int GAP       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [23:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_halt,
    output logic        cpu_dtack,
    input  logic        dma_req,
    input  logic [23:0] dma_addr,
    input  logic [7:0]  dma_dout,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic        dma_ok,
    input  logic        mem_ok,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_we
);

    state_t           state, state_nxt;
    logic             rel_hold, rel_hold_nxt;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             burst_done;

    jtkcpu_busarb_tmr u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

`ifdef JTKCPU_BUSARB_FAIR_EN
    localparam logic [BURST_W:0] BURST_LIM = (BURST_W+1)'(BURST_MAX);

    logic [BURST_W-1:0] burst_cnt;
    logic               burst_inc;

    assign burst_inc  = (state == ST_DMA) && mem_ok && dma_req;
    // Leave on the tick that completes the BURST_MAX-th transfer.
    assign burst_done = ({1'b0, burst_cnt} + {{BURST_W{1'b0}}, burst_inc}) >= BURST_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (cen) begin
            if (state != ST_DMA) begin
                burst_cnt <= '0;
            end else if (burst_inc) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end
`else
    // Without fairness the grant lasts until the request drops; the limit never fires.
    assign burst_done = (BURST_MAX < 0);
`endif

    always_comb begin
        state_nxt    = state;
        rel_hold_nxt = rel_hold;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        case (state)
            ST_CPU: begin
                rel_hold_nxt = 1'b0;
                if (dma_req && !rel_hold) begin
                    state_nxt = ST_HREQ;
                    tmr_load  = 1'b1;
                    tmr_val   = tmr_preset(HALT_LAT);
                end
            end
            ST_HREQ: begin
                if (!dma_req) begin
                    state_nxt = ST_CPU;
                end else if (tmr_zero) begin
                    state_nxt = ST_DMA;
                end
            end
            ST_DMA: begin
                if (!dma_req || burst_done) begin
                    state_nxt = ST_REL;
                    tmr_load  = 1'b1;
                    tmr_val   = tmr_preset(GAP);
                end
            end
            ST_REL: begin
                if (tmr_zero) begin
                    state_nxt    = ST_CPU;
                    rel_hold_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_CPU;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CPU;
            rel_hold <= 1'b0;
            cpu_halt <= 1'b0;
            dma_gnt  <= 1'b0;
        end else if (cen) begin
            state    <= state_nxt;
            rel_hold <= rel_hold_nxt;
            cpu_halt <= (state_nxt == ST_HREQ) || (state_nxt == ST_DMA);
            dma_gnt  <= (state_nxt == ST_DMA);
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_dout  = cpu_dout;
        mem_we    = cpu_we;
        cpu_dtack = 1'b0;
        dma_ok    = 1'b0;
        case (state)
            ST_CPU, ST_HREQ: begin
                cpu_dtack = mem_ok;
            end
            ST_DMA: begin
                mem_addr = dma_addr;
                mem_dout = dma_dout;
                mem_we   = dma_we;
                dma_ok   = mem_ok;
            end
            ST_REL: begin
                mem_we = 1'b0;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule
